// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes field-level RV32 instruction requests and
// writes them sequentially into instruction memory over a req/ack port.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64,
    parameter int          AW        = 32
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         restart,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   op_sel,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [2:0]                   funct3,
    input  logic [6:0]                   funct7,
    input  logic [31:0]                  imm,
    output logic                         imem_we,
    output logic [AW-1:0]                imem_addr,
    output logic [31:0]                  imem_wdata,
    input  logic                         imem_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         err
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            pend_q, pend_d;
    logic [31:0]     enc;
    logic            legal;
    logic            unused_imm;

    assign unused_imm = &{1'b0, imm[31:21]};

    always_comb begin
        enc = '0;
        case (op_sel)
            3'd0:    enc = {funct7, rs2, rs1, funct3, rd, 7'h33};
            3'd1:    enc = {imm[11:0], rs1, funct3, rd, 7'h13};
            3'd2:    enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
            3'd3:    enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
            3'd4:    enc = {imm[11:0], rs1, funct3, rd, 7'h03};
            3'd5:    enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'h23};
            default: enc = '0;
        endcase
    end

    // Branch and jump offsets must be halfword aligned.
    assign legal = (op_sel < 3'd6) && !((op_sel == 3'd2 || op_sel == 3'd3) && imm[0]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (restart) begin
                    count_d = '0;
                    addr_d  = AW'(BASE_ADDR);
                    err_d   = 1'b0;
                end else if (in_valid) begin
                    if (legal) begin
                        wdata_d = enc;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                pend_d = pend_q | restart;
                if (imem_ack) begin
                    pend_d = 1'b0;
                    if (pend_q | restart) begin
                        count_d = '0;
                        addr_d  = AW'(BASE_ADDR);
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + 1'b1;
                        addr_d  = addr_q + AW'(4);
                        state_d = (count_q + 1'b1 == CW'(DEPTH)) ? FULL : IDLE;
                    end
                end
            end
            FULL: begin
                if (restart) begin
                    count_d = '0;
                    addr_d  = AW'(BASE_ADDR);
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            addr_q  <= AW'(BASE_ADDR);
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign in_ready   = (state_q == IDLE) && !restart;
    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign err        = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench; a DEPTH=64 instance carries the
// main traffic, a DEPTH=4 instance sharing its inputs exercises FULL.
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        arst_n, restart, in_valid, imem_ack;
    logic [2:0]  op_sel, funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        in_ready, imem_we, full, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [6:0]  count;
    logic        s_in_ready, s_we, s_full, s_err;
    logic [31:0] s_addr, s_wdata;
    logic [2:0]  s_count;

    int vectors = 0, miscompares = 0, cyc = 0, acc_cyc = 0, prev = 0;
    logic [31:0] exp_addr = 32'h0;
    logic [63:0] sb[$];
    logic [63:0] e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    instr_encoder_loader dut (
        .clk(clk), .arst_n(arst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
        .count(count), .full(full), .err(err)
    );

    instr_encoder_loader #(.DEPTH(4)) dut_small (
        .clk(clk), .arst_n(arst_n), .restart(restart), .in_valid(in_valid), .in_ready(s_in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata), .imem_ack(imem_ack),
        .count(s_count), .full(s_full), .err(s_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (arst_n && imem_we && imem_ack) begin
            if (sb.size() == 0) check("unexpected_write", 1, 0);
            else begin
                e = sb.pop_front();
                check("imem_addr", imem_addr, e[63:32]);
                check("imem_wdata", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im, input logic [31:0] exp_w, input bit lg);
        int t = 0;
        op_sel = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        else begin
            acc_cyc = cyc;
            if (lg) begin
                sb.push_back({exp_addr, exp_w});
                exp_addr += 4;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        exp_addr = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        arst_n = 0; restart = 0; in_valid = 0; imem_ack = 1;
        op_sel = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; funct7 = 0; imm = 0;
        #12 arst_n = 1;
        @(posedge clk); #1;
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_ready", in_ready, 1);

        send(0, 3, 1, 2, 0, 0, 0, 32'h002081B3, 1);
        check("lat_we", imem_we, 1);
        check("lat_addr", imem_addr, 0);
        check("lat_wdata", imem_wdata, 32'h002081B3);
        @(posedge clk); #1;
        check("single_count", count, 1);
        check("single_we_off", imem_we, 0);
        do_restart();
        check("rs_count", count, 0);
        check("rs_addr", imem_addr, 0);

        send(1, 1, 0, 0, 0, 0, 5, 32'h00500093, 1);
        prev = acc_cyc;
        send(4, 5, 2, 0, 2, 0, 8, 32'h00812283, 1);
        check("tput1", acc_cyc - prev, 2); prev = acc_cyc;
        send(5, 0, 2, 5, 2, 0, 12, 32'h00512623, 1);
        check("tput2", acc_cyc - prev, 2); prev = acc_cyc;
        send(2, 0, 1, 2, 3'd7, 0, -32'sd8, 32'hFE208CE3, 1);
        check("tput3", acc_cyc - prev, 2); prev = acc_cyc;
        send(3, 1, 0, 0, 0, 0, 16, 32'h010000EF, 1);
        check("tput4", acc_cyc - prev, 2);
        @(posedge clk); #1;
        check("b2b_count", count, 5);
        check("b2b_full", full, 0);
        check("small_full", s_full, 1);
        check("small_count", s_count, 4);
        check("small_ready", s_in_ready, 0);

        imem_ack = 0;
        send(0, 7, 8, 9, 0, 7'h20, 0, 32'h409403B3, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_we", imem_we, 1);
            check("hold_addr", imem_addr, 32'h14);
            check("hold_wdata", imem_wdata, 32'h409403B3);
            check("hold_ready", in_ready, 0);
            check("hold_count", count, 5);
        end
        @(posedge clk); #1 imem_ack = 1;
        @(posedge clk); #1;
        check("ack_count", count, 6);
        check("ack_we_off", imem_we, 0);

        send(6, 1, 1, 1, 0, 0, 0, 0, 0);
        check("ill_err", err, 1);
        check("ill_we", imem_we, 0);
        check("ill_count", count, 6);
        do_restart();
        check("rs_err", err, 0);
        check("rs_count2", count, 0);
        check("rs_addr2", imem_addr, 0);
        check("small_rs_full", s_full, 0);
        check("small_rs_count", s_count, 0);
        send(2, 0, 1, 2, 0, 0, 3, 0, 0);
        check("odd_br_err", err, 1);
        check("odd_br_we", imem_we, 0);
        send(1, 2, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFF00113, 1);
        check("post_err_we", imem_we, 1);
        @(posedge clk); #1;
        check("post_err_count", count, 1);
        check("post_err_sticky", err, 1);

        imem_ack = 0;
        send(4, 5, 2, 0, 2, 0, 8, 32'h00812283, 1);
        do_restart();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rsw_addr", imem_addr, 32'h4);
            check("rsw_we", imem_we, 1);
        end
        @(posedge clk); #1 imem_ack = 1;
        @(posedge clk); #1;
        check("rsw_count", count, 0);
        check("rsw_addr0", imem_addr, 0);
        check("rsw_ready", in_ready, 1);
        check("rsw_err", err, 0);

        imem_ack = 0;
        send(5, 0, 2, 5, 2, 0, 12, 32'h00512623, 1);
        check("ar_we_pre", imem_we, 1);
        #2 arst_n = 0;
        #1;
        check("ar_we", imem_we, 0);
        check("ar_addr", imem_addr, 0);
        check("ar_wdata", imem_wdata, 0);
        check("ar_count", count, 0);
        check("ar_full", full, 0);
        check("ar_err", err, 0);
        void'(sb.pop_back());
        exp_addr = 32'h0;
        #2 arst_n = 1;
        imem_ack = 1;
        @(posedge clk); #1;
        check("ar_ready", in_ready, 1);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the decode path: takes field-level instruction requests and encodes them into 32-bit RV32 instruction words.
- Encodes the same six opcode classes that the control unit decodes: ALU_R, ALU_I, BRANCH_EQ, JUMP, LOAD and STORE.
- Writes the encoded words sequentially into instruction memory through a request/acknowledge write port.
- Used by the bench and boot logic to load programs into instruction memory before the core is released.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written.
- DEPTH, 64, maximum number of instructions written before the FULL state.
- AW, 32, width of the instruction memory address.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- arst_n  input  1  reset; asynchronous, active-low.
- restart  input  1  synchronous request to clear the address, count and error state.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid and in_ready are both high.
- op_sel  input  3  0=ALU_R, 1=ALU_I, 2=BRANCH_EQ, 3=JUMP, 4=LOAD, 5=STORE; 6 and 7 are illegal.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field; ignored for BRANCH_EQ (forced 000) and JUMP.
- funct7  input  7  funct7 field; used by ALU_R only.
- imm  input  32  signed immediate, byte offset for BRANCH_EQ and JUMP.
- imem_we  output  1  write request.
- imem_addr  output  AW  write byte address.
- imem_wdata  output  32  encoded instruction word.
- imem_ack  input  1  write completes in any cycle where imem_we and imem_ack are both high.
- count  output  $clog2(DEPTH+1)  number of words written.
- full  output  1  high when count == DEPTH.
- err  output  1  sticky error flag.

Behaviour:
- Reset values: state=IDLE, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0. in_ready is 1 after reset.
- Encodings, with opcodes 33/13/63/6F/03/23 hex:
  - ALU_R: {funct7, rs2, rs1, funct3, rd, 7'h33}.
  - ALU_I: {imm[11:0], rs1, funct3, rd, 7'h13}.
  - LOAD: {imm[11:0], rs1, funct3, rd, 7'h03}.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'h23}.
  - BRANCH_EQ: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63}.
  - JUMP: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F}.
  - Immediate bits above the field width are truncated; no range check is made.
- FSM states are IDLE, WRITE and FULL.
- IDLE:
  - in_ready=1.
  - An accepted legal request registers the encoded word into imem_wdata and moves to WRITE. imem_we is high in the next cycle, giving a latency of 1.
  - An accepted illegal request sets err, writes nothing and stays in IDLE. Illegal means op_sel 6 or 7, or BRANCH_EQ/JUMP with imm[0]=1.
- WRITE:
  - in_ready=0; imem_we=1.
  - imem_addr and imem_wdata are held stable until imem_ack.
  - On ack: imem_we=0, count+1, imem_addr+4. Go to FULL if the new count equals DEPTH, otherwise go to IDLE.
  - Peak throughput is 1 word per 2 cycles, reached when ack is returned in the first WRITE cycle.
- FULL: in_ready=0, full=1, no writes.
- restart:
  - In IDLE or FULL it takes effect in the same cycle: count=0, imem_addr=BASE_ADDR, err=0, state goes to IDLE. In IDLE it has priority over a concurrent request, and in_ready is forced to 0 during that cycle.
  - In WRITE it is latched as pending. The current write completes normally. On the ack cycle count, imem_addr and err are cleared instead of incremented, and the state goes to IDLE.
- err is cleared only by reset or restart. Later legal requests are still processed while err is set.
- Asynchronous reset in mid-WRITE drops imem_we immediately; the partial transfer is discarded.
- imem_addr wraps modulo 2^AW. This is not reachable when BASE_ADDR + 4*DEPTH < 2^AW.

Test Plan:
- Single write: reset, then ALU_R rd=3 rs1=1 rs2=2 funct3=0 funct7=0 → imem_we high one cycle after accept, imem_wdata=0x002081B3, imem_addr=0x0, count=1.
- Back-to-back requests with imem_ack tied high: addi x1,x0,5 / lw x5,8(x2) / sw x5,12(x2) / beq x1,x2,-8 / jal x1,16 →
  - words 0x00500093, 0x00812283, 0x00512623, 0xFE208CE3, 0x010000EF at addresses 0x0, 0x4, 0x8, 0xC, 0x10;
  - one accept every 2 cycles.
- Delayed ack: hold imem_ack low for 5 cycles during WRITE → imem_addr and imem_wdata stable, in_ready=0 throughout; count increments only on the ack cycle.
- Errors:
  - op_sel=6 → err=1, no imem_we, count unchanged.
  - BRANCH_EQ with imm=3 → err=1, no write.
  - A following legal request is still written.
- Full: DEPTH=4, issue 5 requests → full=1 after the 4th ack, in_ready=0, 5th request not accepted. Then restart → count=0, imem_addr=BASE_ADDR, full=0.
- restart during WRITE with ack delayed 3 cycles → the write completes with its original address and data; afterwards count=0, imem_addr=BASE_ADDR, state IDLE.
- Assert arst_n mid-WRITE → imem_we=0 immediately, all outputs at reset values.
